demux_3x8: RTL and testbench



---
 rtl/demux_3x8.sv | 73 +++++++
 tb/tb_demux_3x8.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/demux_3x8.sv
// demux_3x8: registered 3-to-8 one-hot (or one-cold) channel-select decoder.
// The select code presented with en=1 appears on out one clock later.
// An optional sticky hit-status register records which channels were selected.
//
// Parameters:
//   ACTIVE_LOW : 0 = selected line high, others low; 1 = selected line low, others high
// Ports:
//   clk     : rising-edge clock for all state
//   rst_n   : asynchronous active-low reset
//   en      : decode enable, sampled on clk
//   in      : select code 0..7
//   clr_hit : synchronous clear of hit status
//   out     : registered one-hot / one-cold channel select
//   out_vld : registered, high when out carries a decoded selection
//   hit     : sticky per-channel selection record, always active-high
// Build option:
//   DEMUX_3X8_HIT_STATUS_EN : defined = hit register and clr_hit implemented;
//                             undefined = hit tied to zero, clr_hit ignored.
module demux_3x8 #(
  parameter bit ACTIVE_LOW = 1'b0,
  localparam int unsigned SEL_W = 3,
  localparam int unsigned CH_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEL_W-1:0] in,
  input  logic             clr_hit,
  output logic [CH_W-1:0]  out,
  output logic             out_vld,
  output logic [CH_W-1:0]  hit
);

  // All-inactive level of out for the chosen polarity.
  localparam logic [CH_W-1:0] IDLE = {CH_W{ACTIVE_LOW}};

  logic [CH_W-1:0] sel_c;

  // Active-high one-hot decode of the select code.
  always_comb begin
    sel_c = CH_W'(1) << in;
  end

  // Output register; XOR with IDLE applies the polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out     <= IDLE;
      out_vld <= 1'b0;
    end else begin
      out     <= en ? (sel_c ^ IDLE) : IDLE;
      out_vld <= en;
    end
  end

`ifdef DEMUX_3X8_HIT_STATUS_EN
  // Sticky hit record; clear takes priority over a same-cycle selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit <= '0;
    end else if (clr_hit) begin
      hit <= '0;
    end else if (en) begin
      hit <= hit | sel_c;
    end
  end
`else
  // Feature absent: hit reads zero and clr_hit has no effect.
  logic unused_clr_hit;
  assign unused_clr_hit = clr_hit;
  assign hit = '0;
`endif

endmodule

// File: tb/tb_demux_3x8.sv
// tb_demux_3x8: self-checking bench for demux_3x8. Two instances share the
// inputs, one per output polarity, and are compared against a reference model.
module tb_demux_3x8;

  logic       clk = 1'b0;
  logic       run = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] in;
  logic       clr_hit;
  logic [7:0] out0, out1, hit0, hit1;
  logic       vld0, vld1;

  int errors = 0;
  int checks = 0;

  always #5 if (run) clk = ~clk;

  demux_3x8 #(.ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in), .clr_hit(clr_hit),
    .out(out0), .out_vld(vld0), .hit(hit0));

  demux_3x8 #(.ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in), .clr_hit(clr_hit),
    .out(out1), .out_vld(vld1), .hit(hit1));

`ifdef DEMUX_3X8_HIT_STATUS_EN
  localparam bit HIT_ON = 1'b1;
`else
  localparam bit HIT_ON = 1'b0;
`endif

  // Reference model: last sampled selection and a per-channel seen array.
  bit m_vld;
  int m_sel;
  bit m_seen[8];

  function automatic logic [7:0] m_out();
    return m_vld ? 8'(2 ** m_sel) : 8'h00;
  endfunction

  function automatic logic [7:0] m_hit();
    logic [7:0] h = 8'h00;
    for (int k = 0; k < 8; k++) if (HIT_ON && m_seen[k]) h = h + 8'(2 ** k);
    return h;
  endfunction

  task automatic m_reset();
    m_vld = 1'b0;
    m_sel = 0;
    for (int k = 0; k < 8; k++) m_seen[k] = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare both instances against the model.
  task automatic chk_model(input string tag);
    chk({tag, " out0"}, out0, m_out());
    chk({tag, " out1"}, out1, ~m_out());
    chk({tag, " vld0"}, 8'(vld0), 8'(m_vld));
    chk({tag, " vld1"}, 8'(vld1), 8'(m_vld));
    chk({tag, " hit0"}, hit0, m_hit());
    chk({tag, " hit1"}, hit1, m_hit());
  endtask

  // One clock: model samples the same inputs the DUT samples, outputs read 1ns later.
  task automatic tick();
    bit e = en; int s = int'(in); bit c = clr_hit;
    @(posedge clk);
    m_vld = e;
    m_sel = s;
    if (c) for (int k = 0; k < 8; k++) m_seen[k] = 1'b0;
    else if (e) m_seen[s] = 1'b1;
    #1;
  endtask

  typedef struct {
    logic       en;
    logic [2:0] in;
    logic [7:0] exp_out;
    logic       exp_vld;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 3'd0, 8'h01, 1'b1};
    vecs[1] = '{1'b1, 3'd1, 8'h02, 1'b1};
    vecs[2] = '{1'b1, 3'd2, 8'h04, 1'b1};
    vecs[3] = '{1'b1, 3'd3, 8'h08, 1'b1};
    vecs[4] = '{1'b1, 3'd4, 8'h10, 1'b1};
    vecs[5] = '{1'b1, 3'd5, 8'h20, 1'b1};
    vecs[6] = '{1'b1, 3'd6, 8'h40, 1'b1};
    vecs[7] = '{1'b1, 3'd7, 8'h80, 1'b1};
    vecs[8] = '{1'b1, 3'd5, 8'h20, 1'b1};
    vecs[9] = '{1'b0, 3'd5, 8'h00, 1'b0};

    // Reset with the clock stopped.
    rst_n = 1'b1; en = 1'b0; in = 3'd0; clr_hit = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst out0", out0, 8'h00);
    chk("rst out1", out1, 8'hFF);
    chk("rst vld0", 8'(vld0), 8'h00);
    chk("rst hit0", hit0, 8'h00);
    #2 rst_n = 1'b1;
    run = 1'b1;
    tick();
    chk_model("idle");

    // Sweep plus enable gating from the table.
    for (int i = 0; i < 10; i++) begin
      en = vecs[i].en; in = vecs[i].in;
      tick();
      chk($sformatf("vec%0d out0", i), out0, vecs[i].exp_out);
      chk($sformatf("vec%0d out1", i), out1, ~vecs[i].exp_out);
      chk($sformatf("vec%0d vld", i), 8'(vld0), 8'(vecs[i].exp_vld));
      if (vecs[i].exp_vld) chk($sformatf("vec%0d ones", i), 8'($countones(out0)), 8'd1);
      chk_model($sformatf("vec%0d", i));
    end

    // Polarity: one-cold values for codes 3 and 6.
    en = 1'b1; in = 3'd3; tick(); chk("pol in3", out1, 8'hF7);
    in = 3'd6; tick(); chk("pol in6", out1, 8'hBF);

    // Hit sequence after a clear.
    clr_hit = 1'b1; en = 1'b0; tick(); clr_hit = 1'b0;
    chk("hit clr0", hit0, 8'h00);
    en = 1'b1;
    in = 3'd1; tick();
    in = 3'd4; tick();
    in = 3'd4; tick();
    in = 3'd7; tick();
    chk("hit 1447", hit0, HIT_ON ? 8'h92 : 8'h00);
    clr_hit = 1'b1; in = 3'd2; tick(); clr_hit = 1'b0;
    chk("hit clr+en", hit0, 8'h00);
    chk("hit clr+en out", out0, 8'h04);

    // Mid-stream reset between edges, then resume.
    in = 3'd3; tick();
    chk_model("pre-rst");
    #1 rst_n = 1'b0;
    #1;
    m_reset();
    chk("mid rst out0", out0, 8'h00);
    chk("mid rst out1", out1, 8'hFF);
    chk("mid rst vld", 8'(vld0), 8'h00);
    chk("mid rst hit", hit0, 8'h00);
    #1 rst_n = 1'b1;
    in = 3'd6; tick();
    chk("resume out0", out0, 8'h40);
    chk_model("resume");

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 3) != 0);
      in = 3'($urandom_range(0, 7));
      clr_hit = ($urandom_range(0, 9) == 0);
      tick();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
